control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle control unit for the rv32 core; successor to the single-cycle combinational control decode.
- Accepts a full 32-bit instruction over a valid/ready handshake and decodes opcode, funct3 and funct7.
- Drives a registered control word and sequences data-memory accesses with an ack handshake and timeout.
- Sits between fetch and the datapath (ALU, register file, data memory).

Parameters:
- ALU_OP_W, 4, width of alu_op.
- BR_W, 3, width of branch_type.
- MEM_TIMEOUT, 16, cycles in MEM without dmem_ack before a fault. 0 disables the timeout.

Ports:
- clk  in  1  core clock.
- nRst  in  1  asynchronous active-low reset.
- inst_valid  in  1  instruction offered.
- inst  in  32  instruction word.
- inst_ready  out  1  sequencer can accept an instruction.
- dmem_ack  in  1  data memory completed the access.
- alu_op  out  ALU_OP_W  fop_t ALU operation.
- branch_type  out  BR_W  0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 unconditional jump.
- alu_src_imm  out  1  ALU operand B is the immediate.
- mem_to_reg  out  1  writeback source is memory.
- reg_write_en  out  1  register-file write strobe.
- read_mem  out  1  load request.
- write_mem  out  1  store request.
- mem_size  out  2  0 byte, 1 half, 2 word.
- mem_unsigned  out  1  zero-extend the load.
- pc_abs  out  1  jalr absolute target.
- link  out  1  writeback pc+4.
- ctrl_valid  out  1  control word valid this cycle.
- pc_en  out  1  advance PC (one-cycle pulse).
- illegal  out  1  undecodable instruction (pulse with ctrl_valid).
- mem_fault  out  1  memory timeout (one-cycle pulse).

Behaviour:
- FSM states: IDLE, EXEC, MEM.
- inst_ready = (state == IDLE), combinational. inst_ready is 1 out of reset.
- Reset: state IDLE, timeout counter 0, all control outputs 0, including strobes and pulses. Reset is asynchronous: a reset mid-MEM drops read_mem/write_mem immediately.
- IDLE:
  - On inst_valid && inst_ready, decode and register the control word.
  - Go to MEM if the opcode is a load or store, otherwise EXEC.
  - Outputs registered: first visible the cycle after acceptance.
- EXEC, one cycle:
  - ctrl_valid = 1.
  - reg_write_en per decode: R, I-ALU, lui, auipc, jal, jalr write; stores and branches never write.
  - pc_en = 1, then return to IDLE.
  - Throughput: 2 cycles per non-memory instruction.
- Illegal instruction: handled in EXEC with illegal = 1, reg_write_en = 0, write_mem = 0, pc_en = 0, then IDLE.
- MEM:
  - read_mem or write_mem held high from state entry.
  - On the dmem_ack cycle: ctrl_valid = 1, pc_en = 1, reg_write_en = 1 for loads only, return to IDLE.
  - Request strobes are low from the next cycle.
- Timeout:
  - Counter counts cycles in MEM without dmem_ack.
  - When it reaches MEM_TIMEOUT - 1 and dmem_ack is still low: mem_fault = 1 for one cycle, request dropped, pc_en = 0, reg_write_en = 0, go to IDLE.
  - If dmem_ack arrives on that same cycle, the ack wins and no fault is raised.
  - The counter clears on entering MEM.
- dmem_ack outside MEM is ignored.
- mem_size and mem_unsigned come from funct3: lb/lh/lw/lbu/lhu, sb/sh/sw.
- slt/slti map to FOP_SLT; sltu/sltiu map to FOP_SLTU.
- Shift-immediates check funct7: srai only with funct7 = 0100000; any other funct7 is illegal.

Optional Feature:
- Macro: CTRL_SEQ_MULDIV_EN.
- Defined:
  - opcode 0110011 with funct7 = 0000001 decodes to RV32M.
  - Adds a MULDIV state and ports muldiv_start (out, 1-cycle pulse on entry) and muldiv_done (in).
  - alu_op = FOP_MUL + funct3.
  - On muldiv_done: ctrl_valid, reg_write_en and pc_en pulse, then return to IDLE.
- Undefined: that encoding is illegal, and neither the extra ports nor the MULDIV state exist.

Decomposition:
- Package ctrl_pkg:
  - inst_type and fop_t (extended with FOP_SLT, FOP_SLTU, FOP_MUL base).
  - br_t, opcode localparams, mem_size encodings, ctrl_word_t struct.
- Sub-module inst_decoder: purely combinational; inst in, ctrl_word_t plus is_mem and illegal out.
- control_sequencer holds the FSM, the control-word register and the timeout counter.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3) with inst_valid: the next cycle shows alu_op = FOP_ADD, reg_write_en = 1, pc_en = 1, ctrl_valid = 1; inst_ready returns high the following cycle.
- lw (0x0000A183), dmem_ack after 3 cycles: read_mem is high for 4 cycles, mem_size = 2; on the ack cycle reg_write_en = 1, mem_to_reg = 1, pc_en = 1.
- sb (0x00308023), ack after 1 cycle: write_mem = 1, mem_size = 0, reg_write_en = 0 throughout.
- lw with no ack and MEM_TIMEOUT = 16: mem_fault pulses on the 16th MEM cycle, pc_en = 0, state returns to IDLE; in a second run, ack on exactly that cycle gives no fault.
- Illegal word 0xFFFFFFFF: illegal = 1 with ctrl_valid, pc_en = 0, reg_write_en = 0.
- nRst asserted during MEM wait: read_mem drops asynchronously and all outputs are 0; after release, inst_ready = 1.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared types and constants for the rv32 control sequencer (CTRL_SEQ_MULDIV_EN adds MULDIV)
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] MSZ_BYTE = 2'd0;
    localparam logic [1:0] MSZ_HALF = 2'd1;
    localparam logic [1:0] MSZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        INST_R, INST_I, INST_S, INST_B, INST_U, INST_J, INST_X
    } inst_type_t;

    typedef enum logic [3:0] {
        FOP_ADD  = 4'd0,
        FOP_SUB  = 4'd1,
        FOP_SLL  = 4'd2,
        FOP_SLT  = 4'd3,
        FOP_SLTU = 4'd4,
        FOP_XOR  = 4'd5,
        FOP_SRL  = 4'd6,
        FOP_SRA  = 4'd7,
        FOP_OR   = 4'd8,
        FOP_AND  = 4'd9
    } fop_t;

    // Mul/div codes FOP_MUL+funct3 share the upper half of the ALU code space;
    // they are only meaningful to the mul/div unit while it owns the instruction.
    localparam logic [3:0] FOP_MUL = 4'd8;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3,
        BR_GE = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6, BR_JUMP = 3'd7
    } br_t;

    typedef struct packed {
        fop_t       alu_op;
        br_t        branch_type;
        logic       alu_src_imm;
        logic       mem_to_reg;
        logic       reg_write;
        logic       read_mem;
        logic       write_mem;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       pc_abs;
        logic       link;
    } ctrl_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM
`ifdef CTRL_SEQ_MULDIV_EN
        , ST_MULDIV
`endif
    } state_t;

    function automatic inst_type_t inst_type_of(input logic [6:0] opc);
        case (opc)
            OPC_OP:                       return INST_R;
            OPC_OPIMM, OPC_LOAD, OPC_JALR: return INST_I;
            OPC_STORE:                    return INST_S;
            OPC_BRANCH:                   return INST_B;
            OPC_LUI, OPC_AUIPC:           return INST_U;
            OPC_JAL:                      return INST_J;
            default:                      return INST_X;
        endcase
    endfunction

    // Base-ISA ALU operation selected by funct3 alone (funct7 variants handled by caller).
    function automatic fop_t alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return FOP_ADD;
            3'b001:  return FOP_SLL;
            3'b010:  return FOP_SLT;
            3'b011:  return FOP_SLTU;
            3'b100:  return FOP_XOR;
            3'b101:  return FOP_SRL;
            3'b110:  return FOP_OR;
            default: return FOP_AND;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - fetch/datapath/dmem bundle of the control sequencer (CTRL_SEQ_MULDIV_EN adds muldiv ports)
interface control_sequencer_if #(
    parameter int ALU_OP_W = 4,
    parameter int BR_W     = 3
);
    logic                inst_valid;
    logic [31:0]         inst;
    logic                inst_ready;
    logic                dmem_ack;
    logic [ALU_OP_W-1:0] alu_op;
    logic [BR_W-1:0]     branch_type;
    logic                alu_src_imm;
    logic                mem_to_reg;
    logic                reg_write_en;
    logic                read_mem;
    logic                write_mem;
    logic [1:0]          mem_size;
    logic                mem_unsigned;
    logic                pc_abs;
    logic                link;
    logic                ctrl_valid;
    logic                pc_en;
    logic                illegal;
    logic                mem_fault;
`ifdef CTRL_SEQ_MULDIV_EN
    logic                muldiv_start;
    logic                muldiv_done;
`endif

    modport master (
`ifdef CTRL_SEQ_MULDIV_EN
        input  muldiv_done,
        output muldiv_start,
`endif
        input  inst_valid, inst, dmem_ack,
        output inst_ready, alu_op, branch_type, alu_src_imm, mem_to_reg,
               reg_write_en, read_mem, write_mem, mem_size, mem_unsigned,
               pc_abs, link, ctrl_valid, pc_en, illegal, mem_fault
    );

    modport slave (
`ifdef CTRL_SEQ_MULDIV_EN
        output muldiv_done,
        input  muldiv_start,
`endif
        output inst_valid, inst, dmem_ack,
        input  inst_ready, alu_op, branch_type, alu_src_imm, mem_to_reg,
               reg_write_en, read_mem, write_mem, mem_size, mem_unsigned,
               pc_abs, link, ctrl_valid, pc_en, illegal, mem_fault
    );

endinterface

// File: rtl/control_sequencer_inst_decoder.sv
// rtl/control_sequencer_inst_decoder.sv - combinational rv32 decode into a control word (CTRL_SEQ_MULDIV_EN enables RV32M)
module inst_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_word_t  ctrl,
    output logic        is_mem,
`ifdef CTRL_SEQ_MULDIV_EN
    output logic        is_muldiv,
`endif
    output logic        illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign unused_fields = ^{inst[24:15], inst[11:7]};

    ctrl_word_t cw;
    logic       ill;
    logic       mem;
    logic       md;
    inst_type_t itype;

    assign itype = inst_type_of(opc);

    // Decode opcode/funct3/funct7; an illegal word yields an all-zero control word.
    always_comb begin
        cw              = '0;
        ill             = 1'b0;
        mem             = 1'b0;
        md              = 1'b0;
        cw.alu_op       = FOP_ADD;
        cw.alu_src_imm  = (itype == INST_I) || (itype == INST_S) || (itype == INST_U);
        case (opc)
            OPC_LUI, OPC_AUIPC: cw.reg_write = 1'b1;
            OPC_JAL: begin
                cw.branch_type = BR_JUMP;
                cw.link        = 1'b1;
                cw.reg_write   = 1'b1;
            end
            OPC_JALR: begin
                ill            = (f3 != 3'b000);
                cw.branch_type = BR_JUMP;
                cw.pc_abs      = 1'b1;
                cw.link        = 1'b1;
                cw.reg_write   = 1'b1;
            end
            OPC_BRANCH: begin
                cw.alu_op = FOP_SUB;
                case (f3)
                    3'b000:  cw.branch_type = BR_EQ;
                    3'b001:  cw.branch_type = BR_NE;
                    3'b100:  cw.branch_type = BR_LT;
                    3'b101:  cw.branch_type = BR_GE;
                    3'b110:  cw.branch_type = BR_LTU;
                    3'b111:  cw.branch_type = BR_GEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                mem           = 1'b1;
                cw.read_mem   = 1'b1;
                cw.mem_to_reg = 1'b1;
                cw.reg_write  = 1'b1;
                case (f3)
                    3'b000:  cw.mem_size = MSZ_BYTE;
                    3'b001:  cw.mem_size = MSZ_HALF;
                    3'b010:  cw.mem_size = MSZ_WORD;
                    3'b100: begin cw.mem_size = MSZ_BYTE; cw.mem_unsigned = 1'b1; end
                    3'b101: begin cw.mem_size = MSZ_HALF; cw.mem_unsigned = 1'b1; end
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                mem          = 1'b1;
                cw.write_mem = 1'b1;
                case (f3)
                    3'b000:  cw.mem_size = MSZ_BYTE;
                    3'b001:  cw.mem_size = MSZ_HALF;
                    3'b010:  cw.mem_size = MSZ_WORD;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                cw.reg_write = 1'b1;
                cw.alu_op    = alu_from_f3(f3);
                if (f3 == 3'b001) begin
                    ill = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT)       cw.alu_op = FOP_SRA;
                    else if (f7 != F7_BASE) ill = 1'b1;
                end
            end
            OPC_OP: begin
                cw.reg_write = 1'b1;
                if (f7 == F7_BASE) begin
                    cw.alu_op = alu_from_f3(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    cw.alu_op = FOP_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    cw.alu_op = FOP_SRA;
`ifdef CTRL_SEQ_MULDIV_EN
                end else if (f7 == F7_MULDIV) begin
                    md        = 1'b1;
                    cw.alu_op = fop_t'(FOP_MUL + {1'b0, f3});
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
    end

    assign ctrl    = ill ? '0 : cw;
    assign is_mem  = mem & ~ill;
    assign illegal = ill;
`ifdef CTRL_SEQ_MULDIV_EN
    assign is_muldiv = md & ~ill;
`else
    logic unused_md;
    assign unused_md = md;
`endif

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle rv32 control FSM with dmem handshake and timeout (CTRL_SEQ_MULDIV_EN adds MULDIV state)
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 4,
    parameter int BR_W        = 3,
    parameter int MEM_TIMEOUT = 16
)(
    input  logic                clk,
    input  logic                nRst,
    control_sequencer_if.master bus
);

    localparam int CNT_W   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    ctrl_word_t dec_ctrl;
    logic       dec_mem;
    logic       dec_ill;

    state_t     state;
    ctrl_word_t ctrl_q;
    logic       valid_q;
    logic       pc_q;
    logic       wr_q;
    logic       ill_q;
    logic [CNT_W-1:0] cnt;

    logic timeout_hit;
    logic mem_done;
    logic md_done;

`ifdef CTRL_SEQ_MULDIV_EN
    logic dec_muldiv;
    logic start_q;
`endif

    inst_decoder u_dec (
        .inst      (bus.inst),
        .ctrl      (dec_ctrl),
        .is_mem    (dec_mem),
`ifdef CTRL_SEQ_MULDIV_EN
        .is_muldiv (dec_muldiv),
`endif
        .illegal   (dec_ill)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));
    // Ack has priority over the timeout on the same cycle.
    assign mem_done    = (state == ST_MEM) && bus.dmem_ack;

    // Sequencer FSM: accepts in IDLE, one EXEC cycle or a MEM wait, back to IDLE.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= ST_IDLE;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            pc_q    <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            cnt     <= '0;
`ifdef CTRL_SEQ_MULDIV_EN
            start_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            pc_q    <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
`ifdef CTRL_SEQ_MULDIV_EN
            start_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (bus.inst_valid) begin
                        ctrl_q <= dec_ctrl;
                        cnt    <= '0;
                        if (dec_mem) begin
                            state <= ST_MEM;
`ifdef CTRL_SEQ_MULDIV_EN
                        end else if (dec_muldiv) begin
                            state   <= ST_MULDIV;
                            start_q <= 1'b1;
`endif
                        end else begin
                            state   <= ST_EXEC;
                            valid_q <= 1'b1;
                            pc_q    <= ~dec_ill;
                            wr_q    <= dec_ctrl.reg_write;
                            ill_q   <= dec_ill;
                        end
                    end
                end
                ST_EXEC: state <= ST_IDLE;
                ST_MEM: begin
                    if (bus.dmem_ack || timeout_hit) begin
                        state            <= ST_IDLE;
                        ctrl_q.read_mem  <= 1'b0;
                        ctrl_q.write_mem <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef CTRL_SEQ_MULDIV_EN
                ST_MULDIV: if (bus.muldiv_done) state <= ST_IDLE;
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CTRL_SEQ_MULDIV_EN
    assign md_done          = (state == ST_MULDIV) && bus.muldiv_done;
    assign bus.muldiv_start = start_q;
`else
    assign md_done = 1'b0;
`endif

    assign bus.inst_ready   = (state == ST_IDLE);
    assign bus.ctrl_valid   = valid_q | mem_done | md_done;
    assign bus.pc_en        = pc_q | mem_done | md_done;
    assign bus.reg_write_en = wr_q | (mem_done & ctrl_q.reg_write) | md_done;
    assign bus.illegal      = ill_q;
    assign bus.mem_fault    = (state == ST_MEM) && !bus.dmem_ack && timeout_hit;
    assign bus.alu_op       = ALU_OP_W'(ctrl_q.alu_op);
    assign bus.branch_type  = BR_W'(ctrl_q.branch_type);
    assign bus.alu_src_imm  = ctrl_q.alu_src_imm;
    assign bus.mem_to_reg   = ctrl_q.mem_to_reg;
    assign bus.read_mem     = ctrl_q.read_mem;
    assign bus.write_mem    = ctrl_q.write_mem;
    assign bus.mem_size     = ctrl_q.mem_size;
    assign bus.mem_unsigned = ctrl_q.mem_unsigned;
    assign bus.pc_abs       = ctrl_q.pc_abs;
    assign bus.link         = ctrl_q.link;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer with a behavioural decode model
module tb_control_sequencer;
    import ctrl_pkg::*;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    control_sequencer_if bus ();

    control_sequencer #(.ALU_OP_W(4), .BR_W(3), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit legal, ld, st, rw, imm, m2r, uns, pabs, lnk;
        int alu, br, sz;
    } exp_t;

    int alu_tab [8];
    int br_tab  [8];
    logic [6:0] opc_tab [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ISA-level expectation for one instruction word.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [6:0] opc = w[6:0];
        logic [2:0] f3  = w[14:12];
        logic [6:0] f7  = w[31:25];
        e = '{default: 0};
        e.alu = FOP_ADD;
        case (opc)
            7'h37, 7'h17: begin e.legal = 1; e.rw = 1; e.imm = 1; end
            7'h6F: begin e.legal = 1; e.rw = 1; e.br = 7; e.lnk = 1; end
            7'h67: begin e.legal = (f3 == 0); e.rw = 1; e.br = 7; e.lnk = 1; e.pabs = 1; e.imm = 1; end
            7'h63: begin e.legal = !(f3 inside {3'd2, 3'd3}); e.br = br_tab[f3]; e.alu = FOP_SUB; end
            7'h03: begin
                e.legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                e.ld = 1; e.rw = 1; e.imm = 1; e.m2r = 1; e.sz = f3[1:0]; e.uns = f3[2];
            end
            7'h23: begin e.legal = (f3 <= 2); e.st = 1; e.imm = 1; e.sz = f3[1:0]; end
            7'h13: begin
                e.rw = 1; e.imm = 1; e.alu = alu_tab[f3];
                if (f3 == 1) e.legal = (f7 == 0);
                else if (f3 == 5) begin
                    e.legal = (f7 == 0) || (f7 == 7'h20);
                    if (f7 == 7'h20) e.alu = FOP_SRA;
                end else e.legal = 1;
            end
            7'h33: begin
                e.rw = 1; e.alu = alu_tab[f3];
                if (f7 == 0) e.legal = 1;
                else if (f7 == 7'h20 && f3 == 0) begin e.legal = 1; e.alu = FOP_SUB; end
                else if (f7 == 7'h20 && f3 == 5) begin e.legal = 1; e.alu = FOP_SRA; end
            end
            default: ;
        endcase
        if (!e.legal) e = '{default: 0};
        return e;
    endfunction

    function automatic logic [13:0] exp_fields(input exp_t e);
        return {4'(e.alu), 3'(e.br), e.imm, e.m2r, 2'(e.sz), e.uns, e.pabs, e.lnk};
    endfunction

    function automatic logic [13:0] obs_fields();
        return {bus.alu_op, bus.branch_type, bus.alu_src_imm, bus.mem_to_reg,
                bus.mem_size, bus.mem_unsigned, bus.pc_abs, bus.link};
    endfunction

    function automatic logic [20:0] all_outs();
        return {bus.ctrl_valid, bus.pc_en, bus.reg_write_en, bus.illegal,
                bus.read_mem, bus.write_mem, bus.mem_fault, obs_fields()};
    endfunction

    // Offer a word while idle; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] w);
        bus.inst       = w;
        bus.inst_valid = 1'b1;
        @(negedge clk);
        chk("ready_on_offer", 32'(bus.inst_ready), 32'd1);
        @(posedge clk); #1;
        bus.inst_valid = 1'b0;
        bus.inst       = $urandom;
    endtask

    // Run one instruction; ack_at is the MEM cycle index carrying dmem_ack.
    task automatic run_inst(input logic [31:0] w, input int ack_at);
        exp_t e;
        int   hi;
        bit   done;
        e = model(w);
        issue(w);
        if (e.ld || e.st) begin
            hi   = 0;
            done = 0;
            for (int k = 0; k < 20 && !done; k++) begin
                bus.dmem_ack = (k == ack_at);
                @(negedge clk);
                if (bus.read_mem || bus.write_mem) hi++;
                chk("mem_req", 32'({bus.read_mem, bus.write_mem, bus.inst_ready}), 32'({e.ld, e.st, 1'b0}));
                if (k == ack_at) begin
                    chk("ack_strobes", 32'({bus.ctrl_valid, bus.pc_en, bus.reg_write_en, bus.mem_fault}),
                        32'({1'b1, 1'b1, e.ld, 1'b0}));
                    chk("ack_fields", 32'(obs_fields()), 32'(exp_fields(e)));
                    done = 1;
                end else if (k == TIMEOUT - 1) begin
                    chk("timeout_strobes", 32'({bus.ctrl_valid, bus.pc_en, bus.reg_write_en, bus.mem_fault}), 32'b0001);
                    done = 1;
                end else begin
                    chk("mem_wait", 32'({bus.ctrl_valid, bus.pc_en, bus.reg_write_en, bus.mem_fault}), 32'b0000);
                end
                @(posedge clk); #1;
            end
            bus.dmem_ack = 1'b0;
            chk("mem_completed", 32'(done), 32'd1);
            chk("req_cycles", 32'(hi), 32'((ack_at < TIMEOUT) ? ack_at + 1 : TIMEOUT));
            @(negedge clk);
            chk("mem_after", 32'({bus.read_mem, bus.write_mem, bus.inst_ready, bus.ctrl_valid, bus.mem_fault}), 32'b00100);
        end else begin
            @(negedge clk);
            chk("exec_strobes", 32'({bus.ctrl_valid, bus.pc_en, bus.reg_write_en, bus.illegal,
                                     bus.read_mem, bus.write_mem, bus.inst_ready, bus.mem_fault}),
                32'({1'b1, e.legal, e.rw, !e.legal, 4'b0000}));
            if (e.legal) chk("exec_fields", 32'(obs_fields()), 32'(exp_fields(e)));
            @(negedge clk);
            chk("exec_after", 32'({bus.ctrl_valid, bus.pc_en, bus.reg_write_en, bus.illegal, bus.inst_ready}), 32'b00001);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [6:0]  f7;
        int          d;

        alu_tab = '{FOP_ADD, FOP_SLL, FOP_SLT, FOP_SLTU, FOP_XOR, FOP_SRL, FOP_OR, FOP_AND};
        br_tab  = '{1, 2, 0, 0, 3, 4, 5, 6};
        opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};

        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        bus.dmem_ack   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        chk("reset_ready", 32'(bus.inst_ready), 32'd1);
        @(posedge clk); #1;
        nRst = 1'b1;
        @(posedge clk); #1;

        // Directed: add, lw ack@3, sb ack@1, lw timeout, lw ack on last cycle, illegal.
        run_inst(32'h002081B3, 0);
        run_inst(32'h0000A183, 3);
        run_inst(32'h00308023, 1);
        run_inst(32'h0000A183, 100);
        run_inst(32'h0000A183, TIMEOUT - 1);
        run_inst(32'hFFFFFFFF, 0);
        run_inst(32'h4010D093, 0);
        run_inst(32'h6010D093, 0);

        // Ack while idle is ignored.
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_ignored", 32'({bus.ctrl_valid, bus.pc_en, bus.reg_write_en, bus.mem_fault, bus.inst_ready}), 32'b00001);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("idle_after_ack", 32'({bus.inst_ready, bus.read_mem, bus.write_mem}), 32'b100);
        @(posedge clk); #1;

        // Randomized instructions and ack delays.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            w = {f7, 10'($urandom), 3'($urandom), 5'($urandom), opc_tab[$urandom_range(0, 9)]};
            d = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 6);
            run_inst(w, d);
        end

        // Asynchronous reset while waiting in MEM.
        issue(32'h0000A183);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_req", 32'(bus.read_mem), 32'd1);
        #2;
        nRst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(all_outs()), 32'd0);
        chk("async_reset_ready", 32'(bus.inst_ready), 32'd1);
        @(posedge clk); #1;
        nRst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'({bus.inst_ready, bus.read_mem}), 32'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
